// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
//
// Up/down counter with a built-in button controller. It counts up on a press
// of `u` and down on a press of `d`. Pressing both buttons together clears the
// count. The step size, the upper limit and the limit mode (saturate or wrap)
// are set by parameters. The counter raises one-cycle event flags for each
// step and for each step that hits the limit.
//
// Optional feature: define UPDOWN_AUTOREPEAT_EN to enable auto-repeat. With
// it, a button held on its own steps again after REPEAT_DELAY hold cycles,
// and then every REPEAT_RATE hold cycles after that. Without it, each press
// produces exactly one step.
//
// Parameters:
//   WIDTH        counter width in bits (>= 2)
//   MAX_VAL      upper count limit, 1 .. 2^WIDTH-1
//   STEP         increment/decrement amount, 1 .. MAX_VAL
//   WRAP         0 = saturate at 0 / MAX_VAL, 1 = modulo (MAX_VAL+1)
//   REPEAT_DELAY hold cycles before the first auto-repeat step (>= 1)
//   REPEAT_RATE  hold cycles between later auto-repeat steps (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   u, d         debounced, synchronous up/down buttons
//   count        registered count value
//   z            count == 0 (combinational)
//   m            count == MAX_VAL (combinational)
//   step_pulse   one-cycle flag after each INC/DEC count update
//   limit_pulse  with step_pulse, when that step was clipped or wrapped
// -----------------------------------------------------------------------------
module updown_counter #(
  parameter int WIDTH        = 8,
  parameter int MAX_VAL      = 255,
  parameter int STEP         = 1,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             u,
  input  logic             d,
  output logic [WIDTH-1:0] count,
  output logic             z,
  output logic             m,
  output logic             step_pulse,
  output logic             limit_pulse
);

  // Reject illegal parameter sets when the design is elaborated.
  if (WIDTH < 2 || MAX_VAL < 1 || STEP < 1 || STEP > MAX_VAL ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("updown_counter: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    CLEAR    = 3'd1,
    IDLE     = 3'd2,
    INC      = 3'd3,
    HOLD_INC = 3'd4,
    DEC      = 3'd5,
    HOLD_DEC = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  // Step arithmetic is done one bit wider, so count+STEP and count+MAX_VAL+1
  // cannot overflow before the limit is checked.
  localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH:0]   up_sum;
  logic             up_over;
  logic [WIDTH-1:0] up_val;
  logic             dn_under;
  logic [WIDTH-1:0] dn_val;
  logic             repeat_hit;

  always_comb begin
    up_sum  = {1'b0, count} + STEP_EXT;
    up_over = (up_sum > MAX_EXT);
    if (!up_over)
      up_val = WIDTH'(up_sum);
    else if (WRAP != 0)
      up_val = WIDTH'(up_sum - MOD_EXT);
    else
      up_val = WIDTH'(MAX_EXT);

    dn_under = ({1'b0, count} < STEP_EXT);
    if (!dn_under)
      dn_val = WIDTH'({1'b0, count} - STEP_EXT);
    else if (WRAP != 0)
      // Here count < STEP <= MAX_VAL, so the sum stays below MAX_VAL+1.
      dn_val = WIDTH'({1'b0, count} + MOD_EXT - STEP_EXT);
    else
      dn_val = '0;
  end

  assign z = (count == '0);
  assign m = (count == WIDTH'(MAX_VAL));

`ifdef UPDOWN_AUTOREPEAT_EN
  localparam int REPEAT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW         = $clog2(REPEAT_MAX + 1);

  logic [HW-1:0] hold_cnt;
  logic          repeat_mode;   // 0 until the first repeat of the current press
  logic [HW-1:0] hold_target;

  always_comb begin
    hold_target = repeat_mode ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY);
    // The transition is taken on the held cycle that makes the counter
    // reach the target, so the step lands 1+target cycles after the last one.
    repeat_hit  = (({1'b0, hold_cnt} + 1'b1) >= {1'b0, hold_target});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt    <= '0;
      repeat_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: repeat_mode <= 1'b0;
        INC, DEC: hold_cnt <= '0;
        HOLD_INC: begin
          if (u && !d) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (repeat_hit) repeat_mode <= 1'b1;
          end
        end
        HOLD_DEC: begin
          if (d && !u) begin
            hold_cnt <= hold_cnt + 1'b1;
            if (repeat_hit) repeat_mode <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // State register plus count and event-flag updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      count       <= '0;
      step_pulse  <= 1'b0;
      limit_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      step_pulse  <= 1'b0;
      limit_pulse <= 1'b0;
      case (state)
        CLEAR: count <= '0;
        INC: begin
          count       <= up_val;
          step_pulse  <= 1'b1;
          limit_pulse <= up_over;
        end
        DEC: begin
          count       <= dn_val;
          step_pulse  <= 1'b1;
          limit_pulse <= dn_under;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic. INC and DEC ignore the buttons and always last exactly
  // one cycle.
  always_comb begin
    state_next = state;
    case (state)
      INIT:  state_next = CLEAR;
      CLEAR: state_next = IDLE;
      IDLE: begin
        if (u && d)      state_next = CLEAR;
        else if (u)      state_next = INC;
        else if (d)      state_next = DEC;
      end
      INC: state_next = HOLD_INC;
      DEC: state_next = HOLD_DEC;
      HOLD_INC: begin
        if (u && d)          state_next = CLEAR;
        else if (!u)         state_next = IDLE;
        else if (repeat_hit) state_next = INC;
      end
      HOLD_DEC: begin
        if (u && d)          state_next = CLEAR;
        else if (!d)         state_next = IDLE;
        else if (repeat_hit) state_next = DEC;
      end
      default: state_next = INIT;
    endcase
  end

endmodule

// File: tb/tb_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_counter
//
// Self-checking bench for updown_counter. It drives three instances:
//   inst 0: MAX_VAL=255, STEP=1, WRAP=0
//   inst 1: MAX_VAL=9,   STEP=4, WRAP=0
//   inst 2: MAX_VAL=9,   STEP=4, WRAP=1
// Expected step results are queued when a press is driven. They are popped
// and compared whenever an instance raises step_pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] u_v;
  logic [2:0] d_v;
  logic [7:0] count_v [3];
  logic [2:0] z_v;
  logic [2:0] m_v;
  logic [2:0] step_v;
  logic [2:0] limit_v;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .MAX_VAL(255), .STEP(1), .WRAP(0),
                   .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_a (
    .clk(clk), .reset(reset), .u(u_v[0]), .d(d_v[0]), .count(count_v[0]),
    .z(z_v[0]), .m(m_v[0]), .step_pulse(step_v[0]), .limit_pulse(limit_v[0]));

  updown_counter #(.WIDTH(8), .MAX_VAL(9), .STEP(4), .WRAP(0),
                   .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_b (
    .clk(clk), .reset(reset), .u(u_v[1]), .d(d_v[1]), .count(count_v[1]),
    .z(z_v[1]), .m(m_v[1]), .step_pulse(step_v[1]), .limit_pulse(limit_v[1]));

  updown_counter #(.WIDTH(8), .MAX_VAL(9), .STEP(4), .WRAP(1),
                   .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_c (
    .clk(clk), .reset(reset), .u(u_v[2]), .d(d_v[2]), .count(count_v[2]),
    .z(z_v[2]), .m(m_v[2]), .step_pulse(step_v[2]), .limit_pulse(limit_v[2]));

  typedef struct {
    int inst;
    bit pu;
    bit pd;
    int hold;
    bit exp_pulse;
    int exp_count;
    bit exp_limit;
  } vec_t;

  typedef struct {
    int inst;
    int cnt;
    bit lim;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   max_v [3] = '{255, 9, 9};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Advance to the next falling edge, then score any step pulses.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("limit_without_step_%0d", i), int'(limit_v[i] & ~step_v[i]), 0);
      if (step_v[i]) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_step inst=%0d actual_count=%0d required=no_step", i, count_v[i]);
        end else begin
          e = sbq.pop_front();
          chk("sb_inst", i, e.inst);
          chk($sformatf("sb_count_%0d", i), int'(count_v[i]), e.cnt);
          chk($sformatf("sb_limit_%0d", i), int'(limit_v[i]), int'(e.lim));
          $display("step inst=%0d count=%0d limit=%0d", i, count_v[i], limit_v[i]);
        end
      end
    end
  endtask

  task automatic push(input int inst, input int cnt, input bit lim);
    sb_t e;
    e.inst = inst;
    e.cnt  = cnt;
    e.lim  = lim;
    sbq.push_back(e);
  endtask

  task automatic chk_state(input string name, input int inst, input int exp);
    chk({name, "_count"}, int'(count_v[inst]), exp);
    chk({name, "_z"}, int'(z_v[inst]), int'(exp == 0));
    chk({name, "_m"}, int'(m_v[inst]), int'(exp == max_v[inst]));
  endtask

  initial begin
    // inst 0: single-step presses, then a clear
    vecs.push_back('{0, 1, 0, 2, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 2, 1, 2, 0});
    vecs.push_back('{0, 1, 0, 2, 1, 3, 0});
    vecs.push_back('{0, 0, 1, 2, 1, 2, 0});
    vecs.push_back('{0, 1, 0, 2, 1, 3, 0});
    vecs.push_back('{0, 1, 0, 2, 1, 4, 0});
    vecs.push_back('{0, 1, 0, 2, 1, 5, 0});
    vecs.push_back('{0, 1, 1, 2, 0, 0, 0});
    // inst 1: saturating, MAX_VAL=9, STEP=4
    vecs.push_back('{1, 1, 0, 2, 1, 4, 0});
    vecs.push_back('{1, 1, 0, 2, 1, 8, 0});
    vecs.push_back('{1, 1, 0, 2, 1, 9, 1});
    vecs.push_back('{1, 1, 0, 2, 1, 9, 1});
    vecs.push_back('{1, 0, 1, 2, 1, 5, 0});
    vecs.push_back('{1, 0, 1, 2, 1, 1, 0});
    vecs.push_back('{1, 0, 1, 2, 1, 0, 1});
    // inst 2: wrapping, MAX_VAL=9, STEP=4
    vecs.push_back('{2, 1, 0, 2, 1, 4, 0});
    vecs.push_back('{2, 1, 0, 2, 1, 8, 0});
    vecs.push_back('{2, 1, 0, 2, 1, 2, 1});
    vecs.push_back('{2, 0, 1, 2, 1, 8, 1});

    reset = 1'b1;
    u_v   = '0;
    d_v   = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_state($sformatf("reset_%0d", i), i, 0);
      chk($sformatf("reset_step_%0d", i), int'(step_v[i]), 0);
      chk($sformatf("reset_limit_%0d", i), int'(limit_v[i]), 0);
    end

    // Release with u already high: INIT, CLEAR, then IDLE samples u at edge 3.
    reset  = 1'b0;
    u_v[0] = 1'b1;
    push(0, 1, 0);
    tick();
    tick();
    tick();
    chk("release_edge3_count", int'(count_v[0]), 0);
    tick();
    chk("release_edge4_count", int'(count_v[0]), 1);
    u_v[0] = 1'b0;
    repeat (3) tick();

    // Reset asserted while in INC: count clears at once, no step follows.
    u_v[0] = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_inc_reset_count", int'(count_v[0]), 0);
    chk("mid_inc_reset_step", int'(step_v[0]), 0);
    u_v[0] = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk_state("after_mid_reset", 0, 0);

    // Table-driven presses.
    for (int k = 0; k < vecs.size(); k++) begin
      u_v[vecs[k].inst] = vecs[k].pu;
      d_v[vecs[k].inst] = vecs[k].pd;
      if (vecs[k].exp_pulse) push(vecs[k].inst, vecs[k].exp_count, vecs[k].exp_limit);
      repeat (vecs[k].hold) tick();
      u_v = '0;
      d_v = '0;
      repeat (3) tick();
      chk_state($sformatf("vec%0d", k), vecs[k].inst, vecs[k].exp_count);
      $display("vec %0d inst=%0d u=%0d d=%0d count=%0d", k, vecs[k].inst,
               vecs[k].pu, vecs[k].pd, count_v[vecs[k].inst]);
    end

    // d raised while in HOLD_INC clears the count.
    u_v[0] = 1'b1;
    push(0, 1, 0);
    tick();
    tick();
    chk("hold_inc_count", int'(count_v[0]), 1);
    d_v[0] = 1'b1;
    tick();
    tick();
    chk("hold_clear_count", int'(count_v[0]), 0);
    u_v = '0;
    d_v = '0;
    repeat (3) tick();
    chk_state("hold_clear_idle", 0, 0);

`ifdef UPDOWN_AUTOREPEAT_EN
    // u held for 19 edges: steps after edges 2, 7, 10, 13, 16, 19.
    u_v[0] = 1'b1;
    for (int k = 1; k <= 6; k++) push(0, k, 0);
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 1)  chk("rep_e1",  int'(count_v[0]), 0);
      if (e == 2)  chk("rep_e2",  int'(count_v[0]), 1);
      if (e == 6)  chk("rep_e6",  int'(count_v[0]), 1);
      if (e == 7)  chk("rep_e7",  int'(count_v[0]), 2);
      if (e == 9)  chk("rep_e9",  int'(count_v[0]), 2);
      if (e == 10) chk("rep_e10", int'(count_v[0]), 3);
      if (e == 19) chk("rep_e19", int'(count_v[0]), 6);
    end
    u_v[0] = 1'b0;
    repeat (10) tick();
    chk_state("rep_release", 0, 6);
`else
    // A long hold without auto-repeat gives exactly one step.
    u_v[0] = 1'b1;
    push(0, 1, 0);
    repeat (20) tick();
    u_v[0] = 1'b0;
    repeat (5) tick();
    chk_state("long_hold", 0, 1);
`endif

    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter with its own button-driven controller, replacing the separate control unit and fixed-width datapath pair. It sits behind the debounced `u`/`d` button inputs and drives the display/decoder stage. It adds configurable width, step size and upper limit, a saturate-or-wrap limit mode, a clear on simultaneous press, and one-cycle event flags. Auto-repeat while a button is held is optional at compile time.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits, ≥2.
- `MAX_VAL`, 255: upper count limit. Must satisfy 1 ≤ MAX_VAL ≤ 2^WIDTH−1.
- `STEP`, 1: increment/decrement amount, 1 ≤ STEP ≤ MAX_VAL.
- `WRAP`, 0: limit mode. 0 = saturate at 0 / MAX_VAL. 1 = modulo (MAX_VAL+1).
- `REPEAT_DELAY`, 50: hold cycles before the first auto-repeat step. Used only with `UPDOWN_AUTOREPEAT_EN`; ≥1.
- `REPEAT_RATE`, 10: hold cycles between later auto-repeat steps. Used only with `UPDOWN_AUTOREPEAT_EN`; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `u` in 1: up button; synchronous, already debounced.
- `d` in 1: down button; synchronous, already debounced.
- `count` out WIDTH: registered count value.
- `z` out 1: combinational, `count == 0`.
- `m` out 1: combinational, `count == MAX_VAL`.
- `step_pulse` out 1: registered; high one cycle after each count change caused by INC or DEC.
- `limit_pulse` out 1: registered; high together with `step_pulse` when the step was clipped (WRAP=0) or wrapped (WRAP=1).

## Operation
- FSM states: INIT, CLEAR, IDLE, INC, HOLD_INC, DEC, HOLD_DEC.
- INIT → CLEAR unconditionally.
- CLEAR: loads `count` to 0 at the cycle's closing edge, then → IDLE.
- IDLE:
  - `u&d` → CLEAR.
  - `u&~d` → INC.
  - `~u&d` → DEC.
  - otherwise stay in IDLE.
- INC: loads `count` with the up-step result, then → HOLD_INC.
- DEC: loads `count` with the down-step result, then → HOLD_DEC.
- HOLD_INC:
  - `u&d` → CLEAR.
  - `~u` → IDLE.
  - otherwise stay in HOLD_INC.
- HOLD_DEC: mirror of HOLD_INC, with `d` as the held button.
- Up step, computed in WIDTH+1 bits so there is no intermediate overflow:
  - if count+STEP ≤ MAX_VAL, result is count+STEP;
  - else WRAP=0 gives MAX_VAL, WRAP=1 gives count+STEP−(MAX_VAL+1);
  - the overflow case sets `limit_pulse`.
- Down step:
  - if count ≥ STEP, result is count−STEP;
  - else WRAP=0 gives 0, WRAP=1 gives count+(MAX_VAL+1)−STEP;
  - the underflow case sets `limit_pulse`.
- An INC taken while already at MAX_VAL with WRAP=0 leaves `count` unchanged, but still asserts `step_pulse` and `limit_pulse`. The same holds for DEC at 0.
- Undefined state encodings → INIT.
- A button change while in INC or DEC is ignored; INC and DEC always last exactly one cycle.

## Timing
- Reset (asynchronous, any state, including mid-step):
  - state = INIT, `count` = 0, `step_pulse` = 0, `limit_pulse` = 0;
  - `z` = 1, `m` = 0 (since MAX_VAL ≥ 1).
- After reset release: INIT one cycle, CLEAR one cycle, IDLE from the third edge.
- Step latency: `u` high at edge E0 while in IDLE → state INC after E0 → new `count`, `step_pulse`, `limit_pulse` visible after E1 → HOLD_INC after E1.
- `step_pulse` is exactly one cycle wide per step.
- Without auto-repeat, a held button produces exactly one step per press.
- Release: `~u` at an edge in HOLD_INC → IDLE after that edge. The minimum press-to-press turnaround is therefore 3 cycles.

## Configuration
- Macro: `UPDOWN_AUTOREPEAT_EN`.
- Defined:
  - a hold counter (width sized to max(REPEAT_DELAY, REPEAT_RATE)) clears on entry to HOLD_INC/HOLD_DEC and increments each cycle the button stays held alone;
  - on reaching REPEAT_DELAY (first repeat of a press) or REPEAT_RATE (later repeats) the FSM → INC/DEC;
  - steps occur 1+REPEAT_DELAY cycles after the first step, then every 1+REPEAT_RATE cycles;
  - release or `u&d` takes priority over the repeat transition.
- Undefined: no hold counter, HOLD states leave only on release or `u&d`, and REPEAT_* are ignored.

## Test plan
- Reset → `count`=0, `z`=1, `m`=0, both pulses 0; release → IDLE on the 3rd edge; assert reset mid-INC → `count`=0 immediately, with no step pulse.
- WIDTH=8, STEP=1: three separate 2-cycle `u` presses → `count`=3 and three `step_pulse`s; one `d` press → `count`=2; `u` held 20 cycles without the macro → exactly one step.
- WRAP=0, MAX_VAL=9, STEP=4 from 0: u,u,u → 4, 8, 9 (third step `limit_pulse`=1, `m`=1); a fourth `u` → stays 9 with `limit_pulse`=1; d,d,d → 5, 1, 0 (last step `limit_pulse`=1).
- WRAP=1, MAX_VAL=9, STEP=4 from 8: `u` → 2 with `limit_pulse`; `d` → 8 with `limit_pulse`.
- `count`=5 in IDLE, `u` and `d` high at the same edge → CLEAR → `count`=0, no `step_pulse`; repeat with `d` raised while in HOLD_INC → `count`=0.
- With `UPDOWN_AUTOREPEAT_EN`, REPEAT_DELAY=4, REPEAT_RATE=2: `u` held from the IDLE edge for 19 edges → `count` steps after edges 2, 7, 10, 13, 16, 19 → 6; release → IDLE, no further steps.
